// File: rtl/ssd1306_spi_rx.sv
// rtl/ssd1306_spi_rx.sv - SSD1306 display-side SPI receiver, command decoder and framebuffer write port
// Optional page addressing mode: define SSD1306_RX_PAGE_MODE_EN.
module ssd1306_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_DC,
  input  logic       i_SPI_CS_n,
  output logic       o_Byte_DV,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DC,
  output logic       o_FB_WE,
  output logic [9:0] o_FB_Addr,
  output logic [7:0] o_FB_Data,
  output logic       o_Display_On,
  output logic [7:0] o_Contrast
);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {S_IDLE, S_ARG} state_t;

  logic [SS-1:0] sclk_sync_q, mosi_sync_q, dc_sync_q, csn_sync_q;
  logic          sclk_prev_q;
  state_t        state_q, state_d;
  logic [1:0]    arg_left_q, arg_left_d, nargs;
  logic [7:0]    cmd_q, cmd_d;
  logic [6:0]    arg0_q, arg0_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_dv_q, byte_dv_d, byte_dc_q, byte_dc_d, fb_we_q, fb_we_d;
  logic [7:0]    byte_q, byte_d, fb_data_q, fb_data_d, contrast_q, contrast_d;
  logic [9:0]    fb_addr_q, fb_addr_d;
  logic          disp_on_q, disp_on_d;
  logic [6:0]    col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
  logic [2:0]    page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d;
`ifdef SSD1306_RX_PAGE_MODE_EN
  logic          page_mode_q, page_mode_d;
`endif

  logic       sclk_s, mosi_s, dc_s, csn_s, bit_stb, byte_stb, is_cmd, is_data;
  logic [7:0] rx_byte;

  assign sclk_s   = sclk_sync_q[SS-1];
  assign mosi_s   = mosi_sync_q[SS-1];
  assign dc_s     = dc_sync_q[SS-1];
  assign csn_s    = csn_sync_q[SS-1];
  assign bit_stb  = sclk_s & ~sclk_prev_q & ~csn_s;
  assign byte_stb = bit_stb & (bit_cnt_q == 3'd7);
  assign rx_byte  = {shift_q[6:0], mosi_s};
  assign is_cmd   = byte_stb & ~dc_s;
  assign is_data  = byte_stb & dc_s;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      dc_sync_q    <= '0;
      csn_sync_q   <= '1;
      sclk_prev_q  <= 1'b0;
      state_q      <= S_IDLE;
      arg_left_q   <= '0;
      cmd_q        <= '0;
      arg0_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_dv_q    <= 1'b0;
      byte_dc_q    <= 1'b0;
      byte_q       <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      disp_on_q    <= 1'b0;
      contrast_q   <= 8'h7F;
      col_start_q  <= '0;
      col_end_q    <= 7'd127;
      col_ptr_q    <= '0;
      page_start_q <= '0;
      page_end_q   <= 3'd7;
      page_ptr_q   <= '0;
`ifdef SSD1306_RX_PAGE_MODE_EN
      page_mode_q  <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SS-2:0], i_SPI_Clk};
      mosi_sync_q  <= {mosi_sync_q[SS-2:0], i_SPI_MOSI};
      dc_sync_q    <= {dc_sync_q[SS-2:0], i_SPI_DC};
      csn_sync_q   <= {csn_sync_q[SS-2:0], i_SPI_CS_n};
      sclk_prev_q  <= sclk_s;
      state_q      <= state_d;
      arg_left_q   <= arg_left_d;
      cmd_q        <= cmd_d;
      arg0_q       <= arg0_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_dv_q    <= byte_dv_d;
      byte_dc_q    <= byte_dc_d;
      byte_q       <= byte_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      disp_on_q    <= disp_on_d;
      contrast_q   <= contrast_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_ptr_q    <= col_ptr_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_ptr_q   <= page_ptr_d;
`ifdef SSD1306_RX_PAGE_MODE_EN
      page_mode_q  <= page_mode_d;
`endif
    end
  end

  // Argument count of each multi-byte command, looked up in IDLE
  always_comb begin
    nargs = 2'd0;
    case (rx_byte)
      8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: nargs = 2'd1;
      8'h21, 8'h22: nargs = 2'd2;
      default: nargs = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    arg_left_d = arg_left_q;
    cmd_d      = cmd_q;
    if (is_data) begin
      state_d    = S_IDLE;
      arg_left_d = 2'd0;
    end else if (is_cmd) begin
      if (state_q == S_IDLE) begin
        if (nargs != 2'd0) begin
          state_d    = S_ARG;
          arg_left_d = nargs;
          cmd_d      = rx_byte;
        end
      end else begin
        arg_left_d = arg_left_q - 2'd1;
        if (arg_left_q == 2'd1) state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_dv_d    = byte_stb;
    byte_dc_d    = byte_stb ? dc_s : byte_dc_q;
    byte_d       = byte_stb ? rx_byte : byte_q;
    fb_we_d      = is_data;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    arg0_d       = arg0_q;
    disp_on_d    = disp_on_q;
    contrast_d   = contrast_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_ptr_d    = col_ptr_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_ptr_d   = page_ptr_q;
`ifdef SSD1306_RX_PAGE_MODE_EN
    page_mode_d  = page_mode_q;
`endif
    if (csn_s) begin
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
    end else if (bit_stb) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = rx_byte;
    end

    if (is_data) begin
      fb_addr_d = {page_ptr_q, col_ptr_q};
      fb_data_d = rx_byte;
`ifdef SSD1306_RX_PAGE_MODE_EN
      if (page_mode_q) col_ptr_d = col_ptr_q + 7'd1;
      else
`endif
      if (col_ptr_q != col_end_q) begin
        col_ptr_d = col_ptr_q + 7'd1;
      end else begin
        col_ptr_d  = col_start_q;
        page_ptr_d = (page_ptr_q == page_end_q) ? page_start_q : page_ptr_q + 3'd1;
      end
    end else if (is_cmd && state_q == S_IDLE) begin
      if (rx_byte == 8'hAE) disp_on_d = 1'b0;
      if (rx_byte == 8'hAF) disp_on_d = 1'b1;
`ifdef SSD1306_RX_PAGE_MODE_EN
      if (page_mode_q) begin
        if (rx_byte[7:3] == 5'b10110) page_ptr_d = rx_byte[2:0];
        if (rx_byte[7:4] == 4'h0)     col_ptr_d[3:0] = rx_byte[3:0];
        if (rx_byte[7:3] == 5'b00010) col_ptr_d[6:4] = rx_byte[2:0];
      end
`endif
    end else if (is_cmd) begin
      // Two-argument window commands commit start and end together
      case (cmd_q)
        8'h81: contrast_d = rx_byte;
        8'h21: begin
          if (arg_left_q == 2'd2) arg0_d = rx_byte[6:0];
          else begin
            col_start_d = arg0_q;
            col_end_d   = rx_byte[6:0];
            col_ptr_d   = arg0_q;
          end
        end
        8'h22: begin
          if (arg_left_q == 2'd2) arg0_d = rx_byte[6:0];
          else begin
            page_start_d = arg0_q[2:0];
            page_end_d   = rx_byte[2:0];
            page_ptr_d   = arg0_q[2:0];
          end
        end
`ifdef SSD1306_RX_PAGE_MODE_EN
        8'h20: page_mode_d = (rx_byte[1:0] == 2'b10);
`endif
        default: ;
      endcase
    end
  end

  assign o_Byte_DV    = byte_dv_q;
  assign o_Byte       = byte_q;
  assign o_Byte_DC    = byte_dc_q;
  assign o_FB_WE      = fb_we_q;
  assign o_FB_Addr    = fb_addr_q;
  assign o_FB_Data    = fb_data_q;
  assign o_Display_On = disp_on_q;
  assign o_Contrast   = contrast_q;
endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// tb/tb_ssd1306_spi_rx.sv - directed and randomized bench for ssd1306_spi_rx against a display-level model
module tb_ssd1306_spi_rx;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, dc = 1'b0, cs_n = 1'b1;
  logic       byte_dv, byte_dc, fb_we, disp_on;
  logic [7:0] byte_o, fb_data, contrast;
  logic [9:0] fb_addr;

  int tests = 0, fails = 0, bad_we = 0, sent = 0;
  int wr_q[$], exp_wr[$], by_q[$];

  // Display-level reference state
  int m_on, m_con, m_cs, m_ce, m_ps, m_pe, m_col, m_pg, m_cmd, m_need, m_page;
  int m_args[$];

  ssd1306_spi_rx #(.SYNC_STAGES(2)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_DC(dc), .i_SPI_CS_n(cs_n), .o_Byte_DV(byte_dv), .o_Byte(byte_o),
    .o_Byte_DC(byte_dc), .o_FB_WE(fb_we), .o_FB_Addr(fb_addr), .o_FB_Data(fb_data),
    .o_Display_On(disp_on), .o_Contrast(contrast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fb_we) begin
      wr_q.push_back({fb_addr, fb_data});
      if (!byte_dv) bad_we++;
    end
    if (byte_dv) by_q.push_back({byte_dc, byte_o});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_on = 0; m_con = 8'h7F; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_col = 0; m_pg = 0; m_need = 0; m_page = 0; m_args.delete();
  endfunction

  function automatic void model_byte(input int b, input bit isdata);
    if (isdata) begin
      m_need = 0;
      exp_wr.push_back(((m_pg * 128 + m_col) << 8) | b);
      if (m_page) m_col = (m_col + 1) % 128;
      else if (m_col == m_ce) begin
        m_col = m_cs;
        m_pg = (m_pg == m_pe) ? m_ps : (m_pg + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else if (m_need > 0) begin
      m_args.push_back(b);
      m_need--;
      if (m_need == 0) begin
        if (m_cmd == 8'h81) m_con = m_args[0];
        if (m_cmd == 8'h21) begin m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs; end
        if (m_cmd == 8'h22) begin m_ps = m_args[0] % 8; m_pe = m_args[1] % 8; m_pg = m_ps; end
`ifdef SSD1306_RX_PAGE_MODE_EN
        if (m_cmd == 8'h20) m_page = ((m_args[0] % 4) == 2);
`endif
      end
    end else begin
      m_cmd = b; m_args.delete();
      if (b == 8'hAE) m_on = 0;
      if (b == 8'hAF) m_on = 1;
      if (b == 8'h21 || b == 8'h22) m_need = 2;
      if (b == 8'h81 || b == 8'h20 || b == 8'h8D || b == 8'hA8 || b == 8'hD3 ||
          b == 8'hD5 || b == 8'hD9 || b == 8'hDA || b == 8'hDB) m_need = 1;
      if (m_page && b >= 8'hB0 && b <= 8'hB7) m_pg = b - 8'hB0;
      if (m_page && b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
      if (m_page && b >= 8'h10 && b <= 8'h17) m_col = (m_col % 16) + (b - 8'h10) * 16;
    end
  endfunction

  task automatic spi_bits(input logic [7:0] b, input bit d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); cs_n = 1'b0; mosi = b[i]; dc = d;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit d);
    spi_bits(b, d, 8);
    repeat (4) @(negedge clk);
    model_byte(b, d);
    sent++;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset(); wr_q.delete(); exp_wr.delete(); by_q.delete(); sent = 0;
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, " write count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check($sformatf("%s write %0d addr/data", tag, i), wr_q[i], exp_wr[i]);
    wr_q.delete(); exp_wr.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " byte_dv"}, byte_dv, 0);
    check({tag, " byte"}, byte_o, 0);
    check({tag, " byte_dc"}, byte_dc, 0);
    check({tag, " fb_we"}, fb_we, 0);
    check({tag, " fb_addr"}, fb_addr, 0);
    check({tag, " fb_data"}, fb_data, 0);
    check({tag, " display_on"}, disp_on, 0);
    check({tag, " contrast"}, contrast, 8'h7F);
  endtask

  initial begin
    int addrs[7];
    int c0, c1, p0, p1, cn;
    addrs = '{130, 131, 132, 258, 259, 260, 130};

    do_reset();
    check_reset_outputs("reset");

    send(8'hAF, 0); send(8'h81, 0); send(8'h3C, 0);
    check("AF display_on", disp_on, 1);
    check("81 contrast", contrast, 8'h3C);
    check("cmd byte pulses", by_q.size(), 3);
    for (int i = 0; i < by_q.size(); i++) check($sformatf("cmd byte %0d dc", i), by_q[i] >> 8, 0);
    check("cmd byte 2 value", by_q.size() > 2 ? by_q[2] : -1, 8'h3C);
    check("cmd no fb write", wr_q.size(), 0);

    send(8'h21, 0); send(8'h02, 0); send(8'h04, 0);
    send(8'h22, 0); send(8'h01, 0); send(8'h02, 0);
    for (int i = 0; i < 7; i++) send(8'h11 + i, 1);
    for (int i = 0; i < 7 && i < wr_q.size(); i++) check($sformatf("window addr %0d", i), wr_q[i] >> 8, addrs[i]);
    cmp_writes("window");

    do_reset();
    spi_bits(8'hA5, 0, 5);
    @(negedge clk); cs_n = 1'b1; repeat (4) @(negedge clk);
    send(8'h3C, 1);
    check("partial byte writes", wr_q.size(), 1);
    check("partial byte addr/data", wr_q.size() > 0 ? wr_q[0] : -1, 8'h3C);
    cmp_writes("partial");

    do_reset();
    send(8'h81, 0); send(8'h55, 1); send(8'hAF, 0);
    check("abandoned arg contrast", contrast, 8'h7F);
    check("abandoned arg write", wr_q.size() > 0 ? wr_q[0] : -1, 8'h55);
    check("abandoned arg then AF", disp_on, 1);
    cmp_writes("abandon");

    do_reset();
    for (int i = 0; i < 1025; i++) send(8'($urandom), 1);
    check("fill addr 1023", wr_q.size() > 1023 ? wr_q[1023] >> 8 : -1, 1023);
    check("fill wrap addr", wr_q.size() > 1024 ? wr_q[1024] >> 8 : -1, 0);
    check("fill dv count", by_q.size(), 1025);
    cmp_writes("fill");

    for (int r = 0; r < 4; r++) begin
      do_reset();
      c0 = $urandom_range(0, 255); c1 = $urandom_range(0, 255);
      p0 = $urandom_range(0, 255); p1 = $urandom_range(0, 255); cn = $urandom_range(0, 255);
      send(8'h21, 0); send(8'(c0), 0); send(8'(c1), 0);
      @(negedge clk); cs_n = 1'b1; repeat (3) @(negedge clk);
      send(8'h22, 0); send(8'(p0), 0);
      @(negedge clk); cs_n = 1'b1; repeat (3) @(negedge clk);
      send(8'(p1), 0);
      send(8'h81, 0); send(8'(cn), 0); send(8'hA8, 0); send(8'h3F, 0);
      for (int i = 0; i < 24; i++) send(8'($urandom), 1);
      check($sformatf("rand%0d contrast", r), contrast, m_con);
      check($sformatf("rand%0d dv count", r), by_q.size(), sent);
      cmp_writes($sformatf("rand%0d", r));
    end

    do_reset();
    send(8'h81, 0);
    spi_bits(8'h12, 0, 4);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    cs_n = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1; repeat (3) @(negedge clk);
    model_reset(); wr_q.delete(); exp_wr.delete();
    send(8'hAF, 0);
    check("post reset AF display_on", disp_on, 1);
    check("post reset contrast", contrast, 8'h7F);

`ifdef SSD1306_RX_PAGE_MODE_EN
    do_reset();
    send(8'h20, 0); send(8'h02, 0); send(8'hB3, 0); send(8'h05, 0); send(8'h12, 0);
    send(8'hAA, 1);
    check("page mode addr/data", wr_q.size() > 0 ? wr_q[0] : -1, (421 << 8) | 8'hAA);
    cmp_writes("page mode");
`endif

    check("fb_we without byte_dv", bad_we, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ssd1306_spi_rx.md
Name: ssd1306_spi_rx

Overview:
SSD1306-side SPI receiver: the display end of the 4-wire link our SSD1306 driver produces (SCLK, MOSI, DC, CS).
- Oversamples the SPI pins on the system clock and deserialises bytes.
- Decodes command bytes (DC=0) and their argument bytes.
- Turns data bytes (DC=1) into write strobes on a 128x8-page framebuffer port.
- Used as an on-chip display model for loopback testing and as a bus monitor.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser (min 2).

Ports:
i_Clk  in  1  system clock.
i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low.
i_SPI_Clk  in  1  SPI SCLK, mode 0 (CPOL=0, CPHA=0); asynchronous to i_Clk.
i_SPI_MOSI  in  1  serial data, MSB first.
i_SPI_DC  in  1  1=data, 0=command.
i_SPI_CS_n  in  1  chip select, active low.
o_Byte_DV  out  1  one-cycle pulse: byte complete.
o_Byte  out  8  last received byte.
o_Byte_DC  out  1  DC value sampled with bit 0 of o_Byte.
o_FB_WE  out  1  one-cycle framebuffer write strobe.
o_FB_Addr  out  10  page*128 + column.
o_FB_Data  out  8  framebuffer write data.
o_Display_On  out  1  set by 0xAF, cleared by 0xAE.
o_Contrast  out  8  value set by 0x81.

Behaviour:
Reset values:
- All outputs 0, except o_Contrast=0x7F.
- Internal state: bit count 0, shift register 0, column window 0..127, page window 0..7, column pointer 0, page pointer 0, no pending arguments, horizontal addressing.

Input capture:
- All four SPI inputs pass through SYNC_STAGES-flop synchronisers.
- SCLK rising edge is detected on the synchronised signal (previous=0, current=1).
- Each SCLK level must be held >=2 i_Clk cycles; faster SCLK is unsupported.

Shift logic:
- On each SCLK rising edge with CS_n=0, shift MOSI in at the LSB and increment the 3-bit count.
- On the 8th bit, latch the byte and DC. The next cycle: o_Byte_DV=1, o_Byte and o_Byte_DC updated. Latency is 1 i_Clk after the synchronised rising edge.
- CS_n high clears the bit count and discards a partial byte. Pending-argument state is kept across CS_n toggles.

Command decoder (DC=0), states IDLE and ARG:
- IDLE:
  - 0xAE / 0xAF: display off / on.
  - 0x81: 1 argument, goes to o_Contrast.
  - 0x21: 2 arguments, column start/end, each masked to [6:0]. After the 2nd argument the column pointer is set to start.
  - 0x22: 2 arguments, page start/end, each masked to [2:0]. After the 2nd argument the page pointer is set to start.
  - 0x20, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: 1 argument, consumed and ignored (see optional feature for 0x20).
  - Any other byte: single-byte command, ignored.
- ARG: decrement the remaining-argument count and store the argument. Return to IDLE when the count reaches 0.
- If a DC=1 byte arrives in ARG: abandon the remaining arguments, return to IDLE, and process the byte as data.

Data path (DC=1):
- Issue o_FB_WE for one cycle, in the same cycle as o_Byte_DV.
- o_FB_Addr = {page_ptr, col_ptr} using the pre-increment pointer. o_FB_Data = the byte.
- Horizontal mode pointer update:
  - col_ptr != col_end: col_ptr+1.
  - col_ptr == col_end: col_ptr=col_start, then page_ptr advances. page_ptr == page_end wraps to page_start; otherwise page_ptr+1.
- Window compares are equality only. If start > end, the pointer counts up through 127 (column) or 7 (page) with natural mod-128 / mod-8 wrap until it reaches end.
- A data byte never alters command state. A command byte never writes the framebuffer.

Optional Feature:
Macro SSD1306_RX_PAGE_MODE_EN.
Defined:
- 0x20 argument [1:0] is stored: 00 = horizontal, 10 = page mode, 01/11 = treated as horizontal.
- In page mode, 0xB0-0xB7 sets page_ptr=[2:0].
- In page mode, 0x00-0x0F sets col_ptr[3:0] and 0x10-0x17 sets col_ptr[6:4].
- Page-mode data increments only col_ptr, wrapping 127->0; page_ptr is unchanged.
Undefined:
- 0x20 argument is consumed and ignored; always horizontal.
- 0x00-0x1F and 0xB0-0xB7 are single-byte ignored commands.

Test Plan:
Serial sequence AF 81 3C (DC=0) -> o_Display_On=1, o_Contrast=0x3C, 3 o_Byte_DV pulses with o_Byte_DC=0, no o_FB_WE.
Commands 21 02 04, 22 01 02, then 7 data bytes 11..17 -> writes at addrs 130,131,132,258,259,260,130.
CS_n raised after 5 bits of 0xA5, then full byte 0x3C as data -> exactly one o_FB_WE, data 0x3C, addr 0.
Command 81 followed by a DC=1 byte 0x55 -> o_Contrast stays 0x7F, write of 0x55 at addr 0, the next command byte AF is decoded as a command.
1024 data bytes after reset -> addresses 0..1023 in order, 1025th byte writes addr 0.
Reset (i_Rst_L low) mid-byte and mid-argument -> all outputs at reset values immediately. With SSD1306_RX_PAGE_MODE_EN: 20 02 B3 05 12 then data 0xAA -> write at addr 3*128+37=421.
